dallanma_ongoru_denetleyici: RTL and testbench

- Fetch-stage next-PC predictor and controller.
- Inputs per fetched instruction: its predecoded branch class (oncoz_pkg::dallanma_turu_t), the raw instruction and its PC.
- Produces a registered next-PC prediction using a 2-bit branch history table (BHT) for conditional branches and a return address stack (RAS) for calls and returns.
- Trained by the execute stage with resolved conditional-branch outcomes; squashed on execute redirect.

---
 rtl/oncoz_pkg.sv | 26 ++
 rtl/donus_adres_yigini.sv | 60 ++++++
 rtl/dallanma_ongoru_denetleyici.sv | 150 +++++++++++++++
 tb/tb_dallanma_ongoru_denetleyici.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/oncoz_pkg.sv
// Shared fetch-stage types: predecode branch class, prediction payload and
// the default predictor depths.
package oncoz_pkg;

    typedef enum logic [1:0] {
        DALLANMA_YOK = 2'd0,
        DALLANMA     = 2'd1,
        JAL          = 2'd2,
        JALR         = 2'd3
    } dallanma_turu_t;

    typedef struct packed {
        logic        gecerli;
        logic        atladi;
        logic [31:0] ps;
    } ongoru_t;

    localparam int unsigned BHT_SATIR_VARSAYILAN    = 64;
    localparam int unsigned RAS_DERINLIK_VARSAYILAN = 8;

    // x1 (ra) and x5 (t0) are the RISC-V link registers.
    function automatic logic baglanti_yazmaci_mi(input logic [4:0] yazmac);
        return (yazmac == 5'd1) || (yazmac == 5'd5);
    endfunction

endpackage

// File: rtl/donus_adres_yigini.sv
// Return address stack: circular buffer, oldest entry overwritten on overflow,
// same-cycle pop+push replaces the top entry.
module donus_adres_yigini
    import oncoz_pkg::*;
#(
    parameter int unsigned DERINLIK = RAS_DERINLIK_VARSAYILAN
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        push,
    input  logic        pop,
    input  logic [31:0] push_veri,
    output logic [31:0] tepe_c,
    output logic        bos_c
);

    localparam int unsigned PW = $clog2(DERINLIK);
    localparam int unsigned CW = $clog2(DERINLIK + 1);

    logic [31:0]   yigin [DERINLIK];
    logic [PW-1:0] isaretci;
    logic [CW-1:0] sayac;
    logic [PW-1:0] tepe_idx;
    logic          pop_etkin;

    // isaretci names the next free slot; the top is the one below it.
    assign tepe_idx  = isaretci - PW'(1);
    assign tepe_c    = yigin[tepe_idx];
    assign bos_c     = (sayac == '0);
    assign pop_etkin = pop && !bos_c;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            isaretci <= '0;
            sayac    <= '0;
        end else if (pop_etkin && push) begin
            isaretci <= isaretci;
            sayac    <= sayac;
        end else if (pop_etkin) begin
            isaretci <= isaretci - PW'(1);
            sayac    <= sayac - CW'(1);
        end else if (push) begin
            isaretci <= isaretci + PW'(1);
            if (sayac != CW'(DERINLIK)) begin
                sayac <= sayac + CW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (pop_etkin && push) begin
                yigin[tepe_idx] <= push_veri;
            end else if (push) begin
                yigin[isaretci] <= push_veri;
            end
        end
    end

endmodule

// File: rtl/dallanma_ongoru_denetleyici.sv
// Fetch-stage next-PC predictor: 2-bit BHT for conditional branches, RAS for
// calls/returns, registered one-cycle prediction.
module dallanma_ongoru_denetleyici
    import oncoz_pkg::*;
#(
    parameter int unsigned BHT_SATIR    = BHT_SATIR_VARSAYILAN,
    parameter int unsigned RAS_DERINLIK = RAS_DERINLIK_VARSAYILAN
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           buyruk_gecerli_i,
    input  logic [31:0]    buyruk_i,
    input  logic [31:0]    ps_i,
    input  dallanma_turu_t dallanma_turu_i,
    input  logic           guncelle_gecerli_i,
    input  logic [31:0]    guncelle_ps_i,
    input  logic           guncelle_atladi_i,
    input  logic           yanlis_ongoru_i,
    output logic           ongoru_gecerli_o,
    output logic           ongoru_atladi_o,
    output logic [31:0]    ongoru_ps_o
);

    localparam int unsigned IW = $clog2(BHT_SATIR);

    function automatic logic [31:0] b_imm(input logic [31:0] b);
        return {{19{b[31]}}, b[31], b[7], b[30:25], b[11:8], 1'b0};
    endfunction

    function automatic logic [31:0] j_imm(input logic [31:0] b);
        return {{11{b[31]}}, b[31], b[19:12], b[20], b[30:21], 1'b0};
    endfunction

    logic [1:0]    bht [BHT_SATIR];
    logic [IW-1:0] oku_idx;
    logic [IW-1:0] yaz_idx;
    logic [4:0]    rd;
    logic [4:0]    rs1;
    logic          rd_bag;
    logic          rs1_bag;
    logic          kabul;
    logic [31:0]   ardisik;
    logic [31:0]   ras_tepe;
    logic          ras_bos;
    logic          atladi_c;
    logic [31:0]   hedef_c;
    logic          push_c;
    logic          pop_c;
    ongoru_t       ongoru_q;
    logic          unused_bitler;

    assign oku_idx = ps_i[IW+1:2];
    assign yaz_idx = guncelle_ps_i[IW+1:2];
    assign rd      = buyruk_i[11:7];
    assign rs1     = buyruk_i[19:15];
    assign rd_bag  = baglanti_yazmaci_mi(rd);
    assign rs1_bag = baglanti_yazmaci_mi(rs1);
    assign kabul   = buyruk_gecerli_i && !yanlis_ongoru_i;
    assign ardisik = ps_i + 32'd4;

    assign unused_bitler = ^{buyruk_i[6:0], guncelle_ps_i[1:0], guncelle_ps_i[31:IW+2]};

    // Saturating 2-bit counter training; reads this cycle see the old value.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < BHT_SATIR; i++) begin
                bht[i] <= 2'b01;
            end
        end else if (guncelle_gecerli_i) begin
            if (guncelle_atladi_i && (bht[yaz_idx] != 2'b11)) begin
                bht[yaz_idx] <= bht[yaz_idx] + 2'd1;
            end else if (!guncelle_atladi_i && (bht[yaz_idx] != 2'b00)) begin
                bht[yaz_idx] <= bht[yaz_idx] - 2'd1;
            end
        end
    end

    // Per-class decision: direction, target and RAS request.
    always_comb begin
        atladi_c = 1'b0;
        hedef_c  = ardisik;
        push_c   = 1'b0;
        pop_c    = 1'b0;
        case (dallanma_turu_i)
            DALLANMA: begin
                if (bht[oku_idx][1]) begin
                    atladi_c = 1'b1;
                    hedef_c  = ps_i + b_imm(buyruk_i);
                end
            end
            JAL: begin
                atladi_c = 1'b1;
                hedef_c  = ps_i + j_imm(buyruk_i);
                push_c   = rd_bag;
            end
            JALR: begin
                if (rd_bag && !rs1_bag) begin
                    push_c = 1'b1;
                end else if (!rd_bag && rs1_bag) begin
                    if (!ras_bos) begin
                        pop_c    = 1'b1;
                        atladi_c = 1'b1;
                        hedef_c  = ras_tepe;
                    end
                end else if (rd_bag && rs1_bag && (rd != rs1)) begin
                    push_c = 1'b1;
                    if (!ras_bos) begin
                        pop_c    = 1'b1;
                        atladi_c = 1'b1;
                        hedef_c  = ras_tepe;
                    end
                end else if (rd_bag) begin
                    push_c = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    donus_adres_yigini #(
        .DERINLIK (RAS_DERINLIK)
    ) u_ras (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .push      (push_c && kabul),
        .pop       (pop_c && kabul),
        .push_veri (ardisik),
        .tepe_c    (ras_tepe),
        .bos_c     (ras_bos)
    );

    // Outputs hold their last value while not valid.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ongoru_q <= '0;
        end else begin
            ongoru_q.gecerli <= kabul;
            if (kabul) begin
                ongoru_q.atladi <= atladi_c;
                ongoru_q.ps     <= hedef_c;
            end
        end
    end

    assign ongoru_gecerli_o = ongoru_q.gecerli;
    assign ongoru_atladi_o  = ongoru_q.atladi;
    assign ongoru_ps_o      = ongoru_q.ps;

endmodule

// File: tb/tb_dallanma_ongoru_denetleyici.sv
// Directed bench for the next-PC predictor: BHT, RAS, squash and reset priority.
module tb_dallanma_ongoru_denetleyici;
    import oncoz_pkg::*;

    logic           clk = 1'b0;
    logic           rst_i;
    logic           buyruk_gecerli_i;
    logic [31:0]    buyruk_i;
    logic [31:0]    ps_i;
    dallanma_turu_t dallanma_turu_i;
    logic           guncelle_gecerli_i;
    logic [31:0]    guncelle_ps_i;
    logic           guncelle_atladi_i;
    logic           yanlis_ongoru_i;
    logic           ongoru_gecerli_o;
    logic           ongoru_atladi_o;
    logic [31:0]    ongoru_ps_o;
    logic [33:0]    gozlem;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] BEQ16    = 32'h0000_0863;
    localparam logic [31:0] JAL_X1_40 = 32'h0400_00EF;
    localparam logic [31:0] JAL_X1_0 = 32'h0000_00EF;

    always #5 clk = ~clk;

    assign gozlem = {ongoru_gecerli_o, ongoru_atladi_o, ongoru_ps_o};

    dallanma_ongoru_denetleyici dut (
        .clk_i              (clk),
        .rst_i              (rst_i),
        .buyruk_gecerli_i   (buyruk_gecerli_i),
        .buyruk_i           (buyruk_i),
        .ps_i               (ps_i),
        .dallanma_turu_i    (dallanma_turu_i),
        .guncelle_gecerli_i (guncelle_gecerli_i),
        .guncelle_ps_i      (guncelle_ps_i),
        .guncelle_atladi_i  (guncelle_atladi_i),
        .yanlis_ongoru_i    (yanlis_ongoru_i),
        .ongoru_gecerli_o   (ongoru_gecerli_o),
        .ongoru_atladi_o    (ongoru_atladi_o),
        .ongoru_ps_o        (ongoru_ps_o)
    );

    function automatic logic [31:0] jalr_kod(input logic [4:0] rd, input logic [4:0] rs1);
        return {12'd0, rs1, 3'd0, rd, 7'h67};
    endfunction

    task automatic adim(input dallanma_turu_t tur, input logic [31:0] kod, input logic [31:0] ps,
                        input logic gec, input logic yanlis, input logic g_gec,
                        input logic [31:0] g_ps, input logic g_atl, input logic rst);
        rst_i              = rst;
        dallanma_turu_i    = tur;
        buyruk_i           = kod;
        ps_i               = ps;
        buyruk_gecerli_i   = gec;
        yanlis_ongoru_i    = yanlis;
        guncelle_gecerli_i = g_gec;
        guncelle_ps_i      = g_ps;
        guncelle_atladi_i  = g_atl;
        @(posedge clk);
        #1;
    endtask

    task automatic getir(input dallanma_turu_t tur, input logic [31:0] kod, input logic [31:0] ps);
        adim(tur, kod, ps, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic egit(input logic [31:0] ps, input logic atl);
        adim(DALLANMA_YOK, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, ps, atl, 1'b0);
    endtask

    task automatic test_reset();
        adim(DALLANMA, BEQ16, 32'h100, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        adim(DALLANMA, BEQ16, 32'h100, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        checks++;
        if (gozlem !== 34'h0) begin
            errors++; $display("FAIL reset_state got %h want %h", gozlem, 34'h0);
        end
        adim(DALLANMA_YOK, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        checks++;
        if (gozlem !== 34'h0) begin
            errors++; $display("FAIL idle_after_reset got %h want %h", gozlem, 34'h0);
        end
    endtask

    task automatic test_bht();
        getir(DALLANMA, BEQ16, 32'h100);
        checks++;
        if (gozlem !== {2'b10, 32'h104}) begin
            errors++; $display("FAIL beq_weak_nt got %h want %h", gozlem, {2'b10, 32'h104});
        end
        egit(32'h100, 1'b1);
        checks++;
        if (ongoru_gecerli_o !== 1'b0) begin
            errors++; $display("FAIL update_only_invalid got %b want 0", ongoru_gecerli_o);
        end
        egit(32'h100, 1'b1);
        getir(DALLANMA, BEQ16, 32'h100);
        checks++;
        if (gozlem !== {2'b11, 32'h110}) begin
            errors++; $display("FAIL beq_trained_taken got %h want %h", gozlem, {2'b11, 32'h110});
        end
        for (int i = 0; i < 3; i++) egit(32'h100, 1'b0);
        getir(DALLANMA, BEQ16, 32'h100);
        checks++;
        if (gozlem !== {2'b10, 32'h104}) begin
            errors++; $display("FAIL beq_trained_nt got %h want %h", gozlem, {2'b10, 32'h104});
        end
        // counter at 00: one taken update must leave it not taken
        egit(32'h100, 1'b1);
        getir(DALLANMA, BEQ16, 32'h100);
        checks++;
        if (gozlem !== {2'b10, 32'h104}) begin
            errors++; $display("FAIL beq_sat_low got %h want %h", gozlem, {2'b10, 32'h104});
        end
    endtask

    task automatic test_read_before_write();
        adim(DALLANMA, BEQ16, 32'h180, 1'b1, 1'b0, 1'b1, 32'h180, 1'b1, 1'b0);
        checks++;
        if (gozlem !== {2'b10, 32'h184}) begin
            errors++; $display("FAIL rbw_old_value got %h want %h", gozlem, {2'b10, 32'h184});
        end
        getir(DALLANMA, BEQ16, 32'h180);
        checks++;
        if (gozlem !== {2'b11, 32'h190}) begin
            errors++; $display("FAIL rbw_new_value got %h want %h", gozlem, {2'b11, 32'h190});
        end
    endtask

    task automatic test_ras();
        getir(JAL, JAL_X1_40, 32'h200);
        checks++;
        if (gozlem !== {2'b11, 32'h240}) begin
            errors++; $display("FAIL jal_call got %h want %h", gozlem, {2'b11, 32'h240});
        end
        getir(JALR, jalr_kod(5'd0, 5'd1), 32'h300);
        checks++;
        if (gozlem !== {2'b11, 32'h204}) begin
            errors++; $display("FAIL ret_pop got %h want %h", gozlem, {2'b11, 32'h204});
        end
        getir(JALR, jalr_kod(5'd0, 5'd1), 32'h310);
        checks++;
        if (gozlem !== {2'b10, 32'h314}) begin
            errors++; $display("FAIL ret_after_drain got %h want %h", gozlem, {2'b10, 32'h314});
        end
    endtask

    task automatic test_overflow();
        logic [33:0] bek;
        getir(JALR, jalr_kod(5'd0, 5'd1), 32'h400);
        checks++;
        if (gozlem !== {2'b10, 32'h404}) begin
            errors++; $display("FAIL ret_empty got %h want %h", gozlem, {2'b10, 32'h404});
        end
        for (int k = 0; k < 9; k++) begin
            getir(JAL, JAL_X1_0, 32'h1000 + 32'(16 * k));
            bek = {2'b11, 32'h1000 + 32'(16 * k)};
            checks++;
            if (gozlem !== bek) begin
                errors++; $display("FAIL call_%0d got %h want %h", k, gozlem, bek);
            end
        end
        for (int j = 0; j < 9; j++) begin
            getir(JALR, jalr_kod(5'd0, 5'd1), 32'h2000 + 32'(4 * j));
            if (j < 8) bek = {2'b11, 32'h1004 + 32'(16 * (8 - j))};
            else       bek = {2'b10, 32'h2024};
            checks++;
            if (gozlem !== bek) begin
                errors++; $display("FAIL ret_%0d got %h want %h", j, gozlem, bek);
            end
        end
    endtask

    task automatic test_squash();
        adim(JAL, JAL_X1_40, 32'h200, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        checks++;
        if (ongoru_gecerli_o !== 1'b0) begin
            errors++; $display("FAIL squash_valid got %b want 0", ongoru_gecerli_o);
        end
        getir(JALR, jalr_kod(5'd0, 5'd1), 32'h500);
        checks++;
        if (gozlem !== {2'b10, 32'h504}) begin
            errors++; $display("FAIL squash_no_push got %h want %h", gozlem, {2'b10, 32'h504});
        end
    endtask

    task automatic test_jalr_cases();
        getir(JALR, jalr_kod(5'd1, 5'd6), 32'h600);
        checks++;
        if (gozlem !== {2'b10, 32'h604}) begin
            errors++; $display("FAIL jalr_call got %h want %h", gozlem, {2'b10, 32'h604});
        end
        getir(JALR, jalr_kod(5'd5, 5'd1), 32'h700);
        checks++;
        if (gozlem !== {2'b11, 32'h604}) begin
            errors++; $display("FAIL coroutine_pop got %h want %h", gozlem, {2'b11, 32'h604});
        end
        getir(JALR, jalr_kod(5'd0, 5'd5), 32'h800);
        checks++;
        if (gozlem !== {2'b11, 32'h704}) begin
            errors++; $display("FAIL coroutine_push got %h want %h", gozlem, {2'b11, 32'h704});
        end
        getir(JALR, jalr_kod(5'd5, 5'd1), 32'h880);
        checks++;
        if (gozlem !== {2'b10, 32'h884}) begin
            errors++; $display("FAIL coroutine_empty got %h want %h", gozlem, {2'b10, 32'h884});
        end
        getir(JALR, jalr_kod(5'd0, 5'd1), 32'h890);
        checks++;
        if (gozlem !== {2'b11, 32'h884}) begin
            errors++; $display("FAIL coroutine_empty_push got %h want %h", gozlem, {2'b11, 32'h884});
        end
        getir(JALR, jalr_kod(5'd1, 5'd1), 32'h900);
        checks++;
        if (gozlem !== {2'b10, 32'h904}) begin
            errors++; $display("FAIL same_link got %h want %h", gozlem, {2'b10, 32'h904});
        end
        getir(JALR, jalr_kod(5'd0, 5'd1), 32'h910);
        checks++;
        if (gozlem !== {2'b11, 32'h904}) begin
            errors++; $display("FAIL same_link_push got %h want %h", gozlem, {2'b11, 32'h904});
        end
        getir(JALR, jalr_kod(5'd0, 5'd6), 32'hA00);
        checks++;
        if (gozlem !== {2'b10, 32'hA04}) begin
            errors++; $display("FAIL jalr_plain got %h want %h", gozlem, {2'b10, 32'hA04});
        end
        getir(JALR, jalr_kod(5'd0, 5'd1), 32'hA10);
        checks++;
        if (gozlem !== {2'b10, 32'hA14}) begin
            errors++; $display("FAIL jalr_plain_no_ras got %h want %h", gozlem, {2'b10, 32'hA14});
        end
    endtask

    task automatic test_wrap();
        getir(DALLANMA_YOK, 32'h0000_0013, 32'hFFFF_FFFC);
        checks++;
        if (gozlem !== {2'b10, 32'h0}) begin
            errors++; $display("FAIL pc_wrap got %h want %h", gozlem, {2'b10, 32'h0});
        end
    endtask

    task automatic test_reset_priority();
        for (int i = 0; i < 3; i++) egit(32'h100, 1'b1);
        getir(JAL, JAL_X1_40, 32'h200);
        adim(DALLANMA, BEQ16, 32'h100, 1'b1, 1'b0, 1'b1, 32'h100, 1'b1, 1'b1);
        checks++;
        if (gozlem !== 34'h0) begin
            errors++; $display("FAIL reset_override got %h want %h", gozlem, 34'h0);
        end
        getir(DALLANMA, BEQ16, 32'h100);
        checks++;
        if (gozlem !== {2'b10, 32'h104}) begin
            errors++; $display("FAIL reset_bht_nt got %h want %h", gozlem, {2'b10, 32'h104});
        end
        getir(JALR, jalr_kod(5'd0, 5'd1), 32'h300);
        checks++;
        if (gozlem !== {2'b10, 32'h304}) begin
            errors++; $display("FAIL reset_ras_empty got %h want %h", gozlem, {2'b10, 32'h304});
        end
        egit(32'h100, 1'b1);
        getir(DALLANMA, BEQ16, 32'h100);
        checks++;
        if (gozlem !== {2'b11, 32'h110}) begin
            errors++; $display("FAIL reset_bht_01 got %h want %h", gozlem, {2'b11, 32'h110});
        end
    endtask

    initial begin
        test_reset();
        test_bht();
        test_read_before_write();
        test_ras();
        test_overflow();
        test_squash();
        test_jalr_cases();
        test_wrap();
        test_reset_priority();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
